// File: rtl/instruction_decode.sv
// RV32I decode stage: registers each fetched pc/insn pair and decodes it into
// register fields, immediate, ALU opcode, class flags and an illegal flag.
// Register-file read addresses are driven combinationally so a synchronous
// register file lines its operands up with the registered decode outputs.
module instruction_decode #(
    parameter bit ENABLE_M = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run_in,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] pc_in,
    input  logic [31:0] insn_in,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    output logic        valid_out,
    output logic [31:0] pc_out,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [31:0] imm,
    output logic [2:0]  funct3,
    output logic [4:0]  alu_op,
    output logic        rd_we,
    output logic        is_lui,
    output logic        is_auipc,
    output logic        is_jal,
    output logic        is_jalr,
    output logic        is_branch,
    output logic        is_load,
    output logic        is_store,
    output logic        is_op_imm,
    output logic        is_op,
    output logic        is_system,
    output logic [1:0]  mem_width,
    output logic        mem_unsigned,
    output logic        illegal
);

    localparam int unsigned XLEN    = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned ALU_W   = 5;
    localparam int unsigned FLAGS_W = 10;

    // Bit positions inside the packed class-flag vector
    localparam int unsigned F_LUI    = 9;
    localparam int unsigned F_AUIPC  = 8;
    localparam int unsigned F_JAL    = 7;
    localparam int unsigned F_JALR   = 6;
    localparam int unsigned F_BRANCH = 5;
    localparam int unsigned F_LOAD   = 4;
    localparam int unsigned F_STORE  = 3;
    localparam int unsigned F_OP_IMM = 2;
    localparam int unsigned F_OP     = 1;
    localparam int unsigned F_SYSTEM = 0;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Pipeline register
    logic               valid_q,        valid_d;
    logic [XLEN-1:0]    pc_q,           pc_d;
    logic [REG_W-1:0]   rd_q,           rd_d;
    logic [REG_W-1:0]   rs1_q,          rs1_d;
    logic [REG_W-1:0]   rs2_q,          rs2_d;
    logic [XLEN-1:0]    imm_q,          imm_d;
    logic [2:0]         funct3_q,       funct3_d;
    logic [ALU_W-1:0]   alu_op_q,       alu_op_d;
    logic               rd_we_q,        rd_we_d;
    logic [FLAGS_W-1:0] flags_q,        flags_d;
    logic [1:0]         mem_width_q,    mem_width_d;
    logic               mem_unsigned_q, mem_unsigned_d;
    logic               illegal_q,      illegal_d;

    // Combinational decode of insn_in
    logic [6:0]         opcode;
    logic [2:0]         f3;
    logic [6:0]         f7;
    logic [XLEN-1:0]    imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0]    dec_imm;
    logic [ALU_W-1:0]   dec_alu;
    logic [FLAGS_W-1:0] dec_flags;
    logic               dec_we;
    logic [1:0]         dec_mw;
    logic               dec_mu;
    logic               dec_ill;

    // Decode fields, immediate, class and legality from the fetched word
    always_comb begin
        opcode    = insn_in[6:0];
        f3        = insn_in[14:12];
        f7        = insn_in[31:25];
        imm_i     = {{20{insn_in[31]}}, insn_in[31:20]};
        imm_s     = {{20{insn_in[31]}}, insn_in[31:25], insn_in[11:7]};
        imm_b     = {{19{insn_in[31]}}, insn_in[31], insn_in[7], insn_in[30:25], insn_in[11:8], 1'b0};
        imm_u     = {insn_in[31:12], 12'b0};
        imm_j     = {{11{insn_in[31]}}, insn_in[31], insn_in[19:12], insn_in[20], insn_in[30:21], 1'b0};
        dec_imm   = '0;
        dec_alu   = '0;
        dec_flags = '0;
        dec_we    = 1'b0;
        dec_mw    = 2'b00;
        dec_mu    = 1'b0;
        dec_ill   = (insn_in[1:0] != 2'b11);

        case (opcode)
            OPC_LUI: begin
                dec_flags[F_LUI] = 1'b1;
                dec_imm          = imm_u;
                dec_we           = 1'b1;
            end
            OPC_AUIPC: begin
                dec_flags[F_AUIPC] = 1'b1;
                dec_imm            = imm_u;
                dec_we             = 1'b1;
            end
            OPC_JAL: begin
                dec_flags[F_JAL] = 1'b1;
                dec_imm          = imm_j;
                dec_we           = 1'b1;
            end
            OPC_JALR: begin
                dec_flags[F_JALR] = 1'b1;
                dec_imm           = imm_i;
                dec_we            = 1'b1;
                if (f3 != 3'b000) dec_ill = 1'b1;
            end
            OPC_BRANCH: begin
                dec_flags[F_BRANCH] = 1'b1;
                dec_imm             = imm_b;
                if (f3 == 3'b010 || f3 == 3'b011) dec_ill = 1'b1;
            end
            OPC_LOAD: begin
                dec_flags[F_LOAD] = 1'b1;
                dec_imm           = imm_i;
                dec_we            = 1'b1;
                dec_mw            = f3[1:0];
                dec_mu            = f3[2];
                if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) dec_ill = 1'b1;
            end
            OPC_STORE: begin
                dec_flags[F_STORE] = 1'b1;
                dec_imm            = imm_s;
                dec_mw             = f3[1:0];
                dec_mu             = f3[2];
                if (f3 > 3'b010) dec_ill = 1'b1;
            end
            OPC_OP_IMM: begin
                dec_flags[F_OP_IMM] = 1'b1;
                dec_imm             = imm_i;
                dec_we              = 1'b1;
                dec_alu             = {1'b0, (f3 == 3'b101) ? insn_in[30] : 1'b0, f3};
                if (f3 == 3'b001 && f7 != 7'h00) dec_ill = 1'b1;
                if (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20) dec_ill = 1'b1;
            end
            OPC_OP: begin
                dec_flags[F_OP] = 1'b1;
                dec_we          = 1'b1;
                dec_alu         = {(f7 == 7'h01), f7[5], f3};
                case (f7)
                    7'h00:   ;
                    7'h20:   if (f3 != 3'b000 && f3 != 3'b101) dec_ill = 1'b1;
                    7'h01:   if (!ENABLE_M) dec_ill = 1'b1;
                    default: dec_ill = 1'b1;
                endcase
            end
            OPC_FENCE: ;
            OPC_SYSTEM: begin
                dec_flags[F_SYSTEM] = 1'b1;
                dec_imm             = imm_i;
            end
            default: dec_ill = 1'b1;
        endcase

        // An illegal word is passed down as a live slot with no side effects
        if (dec_ill) begin
            dec_flags = '0;
            dec_we    = 1'b0;
            dec_mw    = 2'b00;
            dec_mu    = 1'b0;
        end
        if (insn_in[11:7] == 5'd0) dec_we = 1'b0;
    end

    // Next pipeline-register state: flush > stall > load (idle fetch loads a bubble)
    always_comb begin
        valid_d        = valid_q;
        pc_d           = pc_q;
        rd_d           = rd_q;
        rs1_d          = rs1_q;
        rs2_d          = rs2_q;
        imm_d          = imm_q;
        funct3_d       = funct3_q;
        alu_op_d       = alu_op_q;
        rd_we_d        = rd_we_q;
        flags_d        = flags_q;
        mem_width_d    = mem_width_q;
        mem_unsigned_d = mem_unsigned_q;
        illegal_d      = illegal_q;

        if (flush || (!stall && !run_in)) begin
            valid_d   = 1'b0;
            rd_we_d   = 1'b0;
            illegal_d = 1'b0;
            flags_d   = '0;
        end else if (!stall) begin
            valid_d        = 1'b1;
            pc_d           = pc_in;
            rd_d           = insn_in[11:7];
            rs1_d          = insn_in[19:15];
            rs2_d          = insn_in[24:20];
            imm_d          = dec_imm;
            funct3_d       = f3;
            alu_op_d       = dec_alu;
            rd_we_d        = dec_we;
            flags_d        = dec_flags;
            mem_width_d    = dec_mw;
            mem_unsigned_d = dec_mu;
            illegal_d      = dec_ill;
        end
    end

    // Pipeline register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q        <= 1'b0;
            pc_q           <= '0;
            rd_q           <= '0;
            rs1_q          <= '0;
            rs2_q          <= '0;
            imm_q          <= '0;
            funct3_q       <= '0;
            alu_op_q       <= '0;
            rd_we_q        <= 1'b0;
            flags_q        <= '0;
            mem_width_q    <= '0;
            mem_unsigned_q <= 1'b0;
            illegal_q      <= 1'b0;
        end else begin
            valid_q        <= valid_d;
            pc_q           <= pc_d;
            rd_q           <= rd_d;
            rs1_q          <= rs1_d;
            rs2_q          <= rs2_d;
            imm_q          <= imm_d;
            funct3_q       <= funct3_d;
            alu_op_q       <= alu_op_d;
            rd_we_q        <= rd_we_d;
            flags_q        <= flags_d;
            mem_width_q    <= mem_width_d;
            mem_unsigned_q <= mem_unsigned_d;
            illegal_q      <= illegal_d;
        end
    end

    // While stalled the register file must keep reading the held instruction's sources
    assign rs1_addr = stall ? rs1_q : insn_in[19:15];
    assign rs2_addr = stall ? rs2_q : insn_in[24:20];

    assign valid_out    = valid_q;
    assign pc_out       = pc_q;
    assign rd           = rd_q;
    assign rs1          = rs1_q;
    assign rs2          = rs2_q;
    assign imm          = imm_q;
    assign funct3       = funct3_q;
    assign alu_op       = alu_op_q;
    assign rd_we        = rd_we_q;
    assign is_lui       = flags_q[F_LUI];
    assign is_auipc     = flags_q[F_AUIPC];
    assign is_jal       = flags_q[F_JAL];
    assign is_jalr      = flags_q[F_JALR];
    assign is_branch    = flags_q[F_BRANCH];
    assign is_load      = flags_q[F_LOAD];
    assign is_store     = flags_q[F_STORE];
    assign is_op_imm    = flags_q[F_OP_IMM];
    assign is_op        = flags_q[F_OP];
    assign is_system    = flags_q[F_SYSTEM];
    assign mem_width    = mem_width_q;
    assign mem_unsigned = mem_unsigned_q;
    assign illegal      = illegal_q;

endmodule

// File: doc/instruction_decode.md
# instruction_decode

Decode stage placed directly downstream of instruction fetch in the mspu RV32I core. It registers each fetched `pc`/`insn` pair and decodes it into register addresses, a sign-extended immediate, an ALU opcode, instruction-class flags and an illegal-instruction flag. It also drives combinational register-file read addresses so a synchronous-read register file returns operands in the same cycle the decoded fields become valid. It has no internal buffering beyond one pipeline register; backpressure comes through `stall`.

## Interface
- `ENABLE_M`, default 1: decode the RV32M ops (`funct7` = 0x01). When 0, these ops are flagged illegal.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `run_in`  in  1  fetch running; `insn_in`/`pc_in` are meaningful only while this is high.
- `stall`  in  1  hold the pipeline register.
- `flush`  in  1  kill the instruction being loaded; insert a bubble.
- `pc_in`  in  32  PC of `insn_in`.
- `insn_in`  in  32  fetched instruction.
- `rs1_addr`, `rs2_addr`  out  5  combinational register-file read addresses.
- `valid_out`  out  1  decoded outputs are a live instruction.
- `pc_out`  out  32  registered PC.
- `rd`, `rs1`, `rs2`  out  5  registered register fields.
- `imm`  out  32  sign-extended immediate.
- `funct3`  out  3  raw `insn[14:12]`.
- `alu_op`  out  5  bit4 = M-op, bit3 = sub/sra, bits2:0 = `funct3`.
- `rd_we`  out  1  writes `rd`; forced 0 when `rd` = 0.
- Class flags, 1 bit each, outputs: `is_lui`, `is_auipc`, `is_jal`, `is_jalr`, `is_branch`, `is_load`, `is_store`, `is_op_imm`, `is_op`, `is_system`.
- `mem_width`  out  2  0 = byte, 1 = half, 2 = word.
- `mem_unsigned`  out  1  LBU/LHU.
- `illegal`  out  1  illegal encoding.

## Operation
**Register update priority:** reset > flush > stall > load.
- **reset:** every registered output is 0, including `valid_out`, `pc_out`, `imm` and all flags.
- **flush:** `valid_out`, `rd_we`, `illegal` and all class flags are 0 on the next cycle. Other fields are don't-care.
- **stall without flush:** all registered outputs hold.
- **load:** when `run_in` = 0, behaves as flush. Otherwise `valid_out` = 1 and all fields are decoded from `insn_in`.

**Read addresses:**
- `rs1_addr` = `stall ? rs1 : insn_in[19:15]`.
- `rs2_addr` = `stall ? rs2 : insn_in[24:20]`.

**Immediates:** standard RV32I I, S, B, U and J formats, always sign-extended from `insn[31]`.
- LUI and AUIPC use the U format: `{insn[31:12], 12'b0}`.
- OP and other formats without an immediate set `imm` = 0.

**alu_op:**
- OP: `{M, funct7[5], funct3}`.
- OP-IMM: `{0, funct3==101 ? insn[30] : 0, funct3}`.
- All other classes: 0 (add).

**Load / store fields:** `mem_width` = `funct3[1:0]`, `mem_unsigned` = `funct3[2]`. Valid for loads and stores only; otherwise 0.

**rd_we:** 1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM and OP, gated by `rd != 0`.

**SYSTEM (0x73):** `is_system` = 1, `rd_we` = 0.

**FENCE (0x0F):** legal no-op. `valid_out` = 1, no flags set, `rd_we` = 0.

**Illegal cases:**
- `insn[1:0]` != 11.
- Unknown opcode.
- OP with `funct7` not 0x00 or 0x20. 0x20 is allowed only for `funct3` 000/101. 0x01 is allowed only when `ENABLE_M` = 1.
- Shift-immediate with `insn[31:25]` not 0x00, or not 0x20 for SRAI.
- LOAD with `funct3` ∈ {3, 6, 7}.
- STORE with `funct3` > 2.
- BRANCH with `funct3` ∈ {2, 3}.
- JALR with `funct3` != 0.

**When `illegal` = 1:** `valid_out` = 1, `rd_we` = 0, all class flags = 0.

## Timing
- Latency is 1 cycle: an instruction presented at edge N with `stall` = 0 appears on the outputs after edge N.
- A stall of any length holds outputs and read addresses stable. The first unstalled edge loads the current `insn_in`.
- `flush` and `stall` asserted together: the flush wins, and `valid_out` = 0 on the next cycle.
- Reset asserted mid-stream clears outputs on the next edge, regardless of `stall` or `flush`.
- `rs*_addr` depend combinationally on `insn_in`, `stall` and the registers. Every other output comes straight from a register.

## Test plan
- ADDI x1,x0,5 (0x00500093), `run_in` = 1 → next cycle `valid_out` = 1, `rd` = 1, `imm` = 5, `is_op_imm` = 1, `alu_op` = 0, `rd_we` = 1.
- SUB x3,x1,x2 (0x402081B3) → `is_op` = 1, `alu_op` = 5'b01000, `rd` = 3, `rs1_addr` = 1 and `rs2_addr` = 2 in the same cycle the instruction is presented.
- BEQ x1,x2,−8 (0xFE208CE3) → `is_branch` = 1, `imm` = 0xFFFFFFF8, `rd_we` = 0. Then LW x5,−4(x2) (0xFFC12283) → `is_load` = 1, `imm` = 0xFFFFFFFC, `mem_width` = 2, `mem_unsigned` = 0, `rd_we` = 1.
- Load ADDI, then hold `stall` high 3 cycles while `insn_in` changes → outputs unchanged and `rs1_addr` = 0 throughout. Then assert `flush` + `stall` together → `valid_out` = 0 next cycle.
- Illegal cases:
  - 0x00000000 → `illegal` = 1, `rd_we` = 0, all flags 0.
  - With `ENABLE_M` = 0, MUL (0x022081B3) → `illegal` = 1.
  - With `ENABLE_M` = 1, MUL (0x022081B3) → `alu_op` = 5'b10000.
  - ADD x0,x1,x2 → `rd_we` = 0.
- Assert `reset` during a stall with valid outputs → next cycle all outputs 0. Then `run_in` = 0 → `valid_out` stays 0.
